// File: rtl/forth_pkg.sv
// Shared definitions for the Forth processor stacks and the instruction decoder.
package forth_pkg;

   localparam int unsigned FS_WIDTH_DEF = 16;
   localparam int unsigned FS_DEPTH_DEF = 16;

   // Stack operation encoding, shared with the decoder.
   typedef enum logic [2:0] {
      FS_NOP       = 3'd0,
      FS_PUSH      = 3'd1,
      FS_POP       = 3'd2,
      FS_WRITE     = 3'd3,
      FS_POP_WRITE = 3'd4,
      FS_SWAP      = 3'd5,
      FS_DUP       = 3'd6,
      FS_OVER      = 3'd7
   } fs_op_e;

   // Source of the data written into a cell.
   typedef enum logic [1:0] {
      FS_SRC_DIN = 2'd0,
      FS_SRC_TOS = 2'd1,
      FS_SRC_NOS = 2'd2
   } fs_src_e;

   // Minimum number of cells an op needs to be legal.
   function automatic int unsigned fs_min_count(input fs_op_e op);
      case (op)
         FS_POP, FS_WRITE, FS_DUP:        return 1;
         FS_POP_WRITE, FS_SWAP, FS_OVER:  return 2;
         default:                         return 0;
      endcase
   endfunction

   // Ops that add a cell and can therefore overflow.
   function automatic logic fs_grows(input fs_op_e op);
      return (op == FS_PUSH) || (op == FS_DUP) || (op == FS_OVER);
   endfunction

endpackage

// File: rtl/forth_stack_ctl.sv
// Stack control: legality check and decode of next count / cell writes.
module forth_stack_ctl
   import forth_pkg::*;
#(
   parameter int unsigned DEPTH = FS_DEPTH_DEF,
   parameter int unsigned CW    = $clog2(DEPTH + 1),
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic [2:0]    op_i,
   input  logic [CW-1:0] count_i,
   output logic          set_ovf_o,
   output logic          set_unf_o,
   output logic [CW-1:0] count_d_o,
   output logic          we_a_o,
   output logic [AW-1:0] waddr_a_o,
   output fs_src_e       src_a_o,
   output logic          we_b_o,
   output logic [AW-1:0] waddr_b_o,
   output fs_src_e       src_b_o
);

   fs_op_e        op;
   logic          legal;
   logic [CW-1:0] idx_tos;
   logic [CW-1:0] idx_nos;

   // Classify the op against the current fill level and decode its effect.
   always_comb begin
      op        = fs_op_e'(op_i);
      idx_tos   = count_i - CW'(1);
      idx_nos   = count_i - CW'(2);
      count_d_o = count_i;
      we_a_o    = 1'b0;
      waddr_a_o = '0;
      src_a_o   = FS_SRC_DIN;
      we_b_o    = 1'b0;
      waddr_b_o = '0;
      src_b_o   = FS_SRC_DIN;

      // Overflow is checked first; a full stack always holds enough cells for DUP/OVER.
      set_ovf_o = fs_grows(op) && (count_i == CW'(DEPTH));
      set_unf_o = !set_ovf_o && (count_i < CW'(fs_min_count(op)));
      legal     = !set_ovf_o && !set_unf_o;

      if (legal) begin
         case (op)
            FS_PUSH: begin
               we_a_o    = 1'b1;
               waddr_a_o = count_i[AW-1:0];
               src_a_o   = FS_SRC_DIN;
               count_d_o = count_i + CW'(1);
            end
            FS_POP: begin
               count_d_o = count_i - CW'(1);
            end
            FS_WRITE: begin
               we_a_o    = 1'b1;
               waddr_a_o = idx_tos[AW-1:0];
               src_a_o   = FS_SRC_DIN;
            end
            FS_POP_WRITE: begin
               we_a_o    = 1'b1;
               waddr_a_o = idx_nos[AW-1:0];
               src_a_o   = FS_SRC_DIN;
               count_d_o = count_i - CW'(1);
            end
            FS_SWAP: begin
               we_a_o    = 1'b1;
               waddr_a_o = idx_tos[AW-1:0];
               src_a_o   = FS_SRC_NOS;
               we_b_o    = 1'b1;
               waddr_b_o = idx_nos[AW-1:0];
               src_b_o   = FS_SRC_TOS;
            end
            FS_DUP: begin
               we_a_o    = 1'b1;
               waddr_a_o = count_i[AW-1:0];
               src_a_o   = FS_SRC_TOS;
               count_d_o = count_i + CW'(1);
            end
            FS_OVER: begin
               we_a_o    = 1'b1;
               waddr_a_o = count_i[AW-1:0];
               src_a_o   = FS_SRC_NOS;
               count_d_o = count_i + CW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/forth_stack.sv
// Parametrised Forth stack: cell storage, fill count and sticky error flags.
module forth_stack
   import forth_pkg::*;
#(
   parameter  int unsigned WIDTH = FS_WIDTH_DEF,
   parameter  int unsigned DEPTH = FS_DEPTH_DEF,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] din,
   input  logic             clr_err,
   output logic [WIDTH-1:0] tos,
   output logic [WIDTH-1:0] nos,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full,
   output logic             ovf,
   output logic             unf
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [CW-1:0]    count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic             set_ovf, set_unf;
   logic             we_a, we_b;
   logic [AW-1:0]    waddr_a, waddr_b;
   fs_src_e          src_a, src_b;
   logic [WIDTH-1:0] wdata_a, wdata_b;
   logic [CW-1:0]    idx_tos, idx_nos;

   forth_stack_ctl #(
      .DEPTH (DEPTH),
      .CW    (CW),
      .AW    (AW)
   ) u_ctl (
      .op_i      (op),
      .count_i   (count_q),
      .set_ovf_o (set_ovf),
      .set_unf_o (set_unf),
      .count_d_o (count_d),
      .we_a_o    (we_a),
      .waddr_a_o (waddr_a),
      .src_a_o   (src_a),
      .we_b_o    (we_b),
      .waddr_b_o (waddr_b),
      .src_b_o   (src_b)
   );

   // Top/next read-out, masked to zero when the stack does not hold them.
   always_comb begin
      idx_tos = count_q - CW'(1);
      idx_nos = count_q - CW'(2);
      tos     = (count_q >= CW'(1)) ? mem_q[idx_tos[AW-1:0]] : '0;
      nos     = (count_q >= CW'(2)) ? mem_q[idx_nos[AW-1:0]] : '0;
      empty   = (count_q == '0);
      full    = (count_q == CW'(DEPTH));
   end

   // Write-data selection; SWAP uses both ports to exchange TOS and NOS.
   always_comb begin
      case (src_a)
         FS_SRC_TOS: wdata_a = tos;
         FS_SRC_NOS: wdata_a = nos;
         default:    wdata_a = din;
      endcase
      case (src_b)
         FS_SRC_TOS: wdata_b = tos;
         FS_SRC_NOS: wdata_b = nos;
         default:    wdata_b = din;
      endcase
   end

   // Sticky flags: a new error in the same cycle as clr_err leaves the flag set.
   always_comb begin
      ovf_d = set_ovf | (ovf_q & ~clr_err);
      unf_d = set_unf | (unf_q & ~clr_err);
   end

   // Count and flags, cleared asynchronously.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Cell storage; contents survive reset and are hidden by the count.
   always_ff @(posedge Clk) begin
      if (we_a) mem_q[waddr_a] <= wdata_a;
      if (we_b) mem_q[waddr_b] <= wdata_b;
   end

   assign count = count_q;
   assign ovf   = ovf_q;
   assign unf   = unf_q;

endmodule
